// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: the single register-file write port is shared by two
// writeback requesters. Requester 0 is ALU writeback and requester 1 is load
// writeback. Each requester has a one-entry holding buffer. A round-robin grant
// drains the buffers into registered Rd/WriteData/RegWrite outputs. Writes to
// the same destination leave in arrival order, and writes to x0 are dropped.
//
// Handshake: a transfer on requester N happens on a rising Clk edge when
// reqN_valid & reqN_ready are both high. reqN_ready is high when bufN is empty,
// or when bufN is granted this cycle, so it can be refilled on the edge that
// drains it. The grant uses registered state only, so ready never depends on
// valid.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              grant_id,
  output logic              busy
);

  // Holding buffers
  logic              buf0_full;
  logic [ADDR_W-1:0] buf0_rd;
  logic [DATA_W-1:0] buf0_data;
  logic              buf1_full;
  logic [ADDR_W-1:0] buf1_rd;
  logic [DATA_W-1:0] buf1_data;

  // rr_ptr: requester preferred on a different-rd conflict.
  // age: 1 when buf1 holds the older entry, 0 when buf0 does.
  logic rr_ptr;
  logic age;

  logic gnt_valid;
  logic gnt_sel;
  logic gnt0;
  logic gnt1;
  logic load0;
  logic load1;
  logic keep0;
  logic keep1;

  // Grant selection from registered buffer state only
  always_comb begin
    gnt_valid = buf0_full | buf1_full;
    gnt_sel   = 1'b0;
    if (buf0_full && buf1_full) begin
      gnt_sel = (buf0_rd == buf1_rd) ? age : rr_ptr;
    end else begin
      gnt_sel = buf1_full;
    end
  end

  assign gnt0 = gnt_valid & ~gnt_sel;
  assign gnt1 = gnt_valid &  gnt_sel;

  assign req0_ready = ~buf0_full | gnt0;
  assign req1_ready = ~buf1_full | gnt1;

  // An accepted x0 write completes its handshake but is never buffered
  assign load0 = req0_valid & req0_ready & (req0_rd != '0);
  assign load1 = req1_valid & req1_ready & (req1_rd != '0);

  // An entry that survives this edge untouched
  assign keep0 = buf0_full & ~gnt0;
  assign keep1 = buf1_full & ~gnt1;

  assign busy = buf0_full | buf1_full;

  // Buffer 0: fill on transfer, empty on grant, refill wins over empty
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      buf0_full <= 1'b0;
      buf0_rd   <= '0;
      buf0_data <= '0;
    end else if (load0) begin
      buf0_full <= 1'b1;
      buf0_rd   <= req0_rd;
      buf0_data <= req0_data;
    end else if (gnt0) begin
      buf0_full <= 1'b0;
    end
  end

  // Buffer 1: fill on transfer, empty on grant, refill wins over empty
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      buf1_full <= 1'b0;
      buf1_rd   <= '0;
      buf1_data <= '0;
    end else if (load1) begin
      buf1_full <= 1'b1;
      buf1_rd   <= req1_rd;
      buf1_data <= req1_data;
    end else if (gnt1) begin
      buf1_full <= 1'b0;
    end
  end

  // Age tracking: the surviving entry is older than a newly loaded one.
  // On a simultaneous fill, req0 counts as older.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      age <= 1'b0;
    end else if (keep0 && load1) begin
      age <= 1'b0;
    end else if (keep1 && load0) begin
      age <= 1'b1;
    end else if (load0 && load1) begin
      age <= 1'b0;
    end
  end

  // Round-robin pointer moves to the non-granted requester after each grant
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr <= 1'b0;
    end else if (gnt_valid) begin
      rr_ptr <= ~gnt_sel;
    end
  end

  // Registered write port: one-cycle RegWrite pulse, address/data hold otherwise
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite  <= 1'b0;
      Rd        <= '0;
      WriteData <= '0;
      grant_id  <= 1'b0;
    end else if (gnt_valid) begin
      RegWrite  <= 1'b1;
      Rd        <= gnt_sel ? buf1_rd   : buf0_rd;
      WriteData <= gnt_sel ? buf1_data : buf0_data;
      grant_id  <= gnt_sel;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter: reset, single stream,
// contention, same-rd ordering, x0 discard and asynchronous reset.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              Clk;
  logic              Reset;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic              grant_id;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .Rd         (Rd),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic port(input string tag, input logic we, input logic [ADDR_W-1:0] rd,
                      input logic [DATA_W-1:0] d, input logic g);
    check({tag, "_regwrite"}, 64'(RegWrite), 64'(we));
    check({tag, "_rd"}, 64'(Rd), 64'(rd));
    check({tag, "_wdata"}, WriteData, d);
    if (we) check({tag, "_grant"}, 64'(grant_id), 64'(g));
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    req0_rd = '0; req0_data = '0; req1_rd = '0; req1_data = '0;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset then idle
    do_reset();
    port("rst", 1'b0, 5'd0, 64'd0, 1'b0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd1);
    check("rst_ready1", 64'(req1_ready), 64'd1);
    step();
    check("idle_regwrite", 64'(RegWrite), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Contention with different rd: grants alternate 0,1,0,1
    begin
      logic [DATA_W-1:0] d0, d1;
      logic er0, er1;
      d0 = 64'd10; d1 = 64'd20;
      req0_valid = 1'b1; req0_rd = 5'd2;
      req1_valid = 1'b1; req1_rd = 5'd5;
      for (int i = 0; i < 8; i++) begin
        req0_data = d0;
        req1_data = d1;
        er0 = (i == 0) ? 1'b1 : ((i % 2) == 1);
        er1 = (i == 0) ? 1'b1 : ((i % 2) == 0);
        check($sformatf("cont_ready0_%0d", i), 64'(req0_ready), 64'(er0));
        check($sformatf("cont_ready1_%0d", i), 64'(req1_ready), 64'(er1));
        step();
        if (er0) d0 = d0 + 1;
        if (er1) d1 = d1 + 1;
        if (i == 0) begin
          check("cont_first_regwrite", 64'(RegWrite), 64'd0);
        end else if (((i - 1) % 2) == 0) begin
          port($sformatf("cont_%0d", i), 1'b1, 5'd2, 64'(10 + (i - 1) / 2), 1'b0);
        end else begin
          port($sformatf("cont_%0d", i), 1'b1, 5'd5, 64'(20 + (i - 1) / 2), 1'b1);
        end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end

    // Single requester stream
    do_reset();
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 64'd100;
    check("ss_ready_a", 64'(req0_ready), 64'd1);
    step();
    check("ss_accept_regwrite", 64'(RegWrite), 64'd0);
    check("ss_busy", 64'(busy), 64'd1);
    req0_rd = 5'd4; req0_data = 64'd101;
    check("ss_ready_b", 64'(req0_ready), 64'd1);
    step();
    port("ss_w1", 1'b1, 5'd3, 64'd100, 1'b0);
    req0_valid = 1'b0;
    check("ss_ready_c", 64'(req0_ready), 64'd1);
    step();
    port("ss_w2", 1'b1, 5'd4, 64'd101, 1'b0);
    step();
    port("ss_hold", 1'b0, 5'd4, 64'd101, 1'b0);
    check("ss_idle_busy", 64'(busy), 64'd0);

    // Same-rd ordering: req1 first, then req0 on the next edge
    do_reset();
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 64'd55;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 64'd66;
    step();
    req0_valid = 1'b0;
    port("ord_w1", 1'b1, 5'd7, 64'd55, 1'b1);
    step();
    port("ord_w2", 1'b1, 5'd7, 64'd66, 1'b0);
    step();
    check("ord_idle", 64'(RegWrite), 64'd0);

    // Same-rd, same edge: pointer now prefers req1, age must give req0 first
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 64'd77;
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 64'd88;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    port("same_w1", 1'b1, 5'd7, 64'd77, 1'b0);
    step();
    port("same_w2", 1'b1, 5'd7, 64'd88, 1'b1);
    step();
    check("same_idle", 64'(RegWrite), 64'd0);

    // x0 discard
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 64'd99;
    check("x0_ready", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    check("x0_busy", 64'(busy), 64'd0);
    check("x0_regwrite_a", 64'(RegWrite), 64'd0);
    step();
    port("x0_b", 1'b0, 5'd7, 64'd88, 1'b0);
    check("x0_busy_b", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 64'd300;
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 64'd400;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    port("ar_pre", 1'b1, 5'd10, 64'd300, 1'b0);
    check("ar_pre_busy", 64'(busy), 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    port("ar_now", 1'b0, 5'd0, 64'd0, 1'b0);
    check("ar_now_busy", 64'(busy), 64'd0);
    check("ar_now_ready1", 64'(req1_ready), 64'd1);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      port($sformatf("ar_post_%0d", i), 1'b0, 5'd0, 64'd0, 1'b0);
      check($sformatf("ar_post_busy_%0d", i), 64'(busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
